// File: rtl/bp_update_fifo.sv
// Buffers resolved branches from execute and drains them in order to the branch predictor update port.
// Latency: an entry pushed on one edge is presented at the update port from the next cycle (no bypass).
// Backpressure: br_ready drops when full or in reset; the head entry is held while update_ready is low.
module bp_update_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    input  logic [31:0] br_pc,
    input  logic        br_prediction,
    input  logic        br_actual,
    input  logic [31:0] br_target,
    output logic        br_ready,
    input  logic        flush,
    input  logic        update_ready,
    output logic        update_valid,
    output logic [31:0] update_pc,
    output logic        update_prediction,
    output logic        update_actual,
    output logic [31:0] update_target,
    output logic [15:0] mispredict_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic        prediction;
        logic        actual;
        logic [31:0] target;
    } entry_t;

    entry_t        slots [DEPTH];
    entry_t        head_entry;
    entry_t        tail_entry;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          head_mispredicted;

    // A full FIFO refuses new entries even when the head drains in the same cycle;
    // this keeps br_ready independent of update_ready.
    assign br_ready     = (count < FULL_COUNT) && !rst;
    assign update_valid = (count != '0);

    assign push = br_valid && br_ready;
    assign pop  = update_valid && update_ready;

    assign tail_entry = '{pc: br_pc, prediction: br_prediction, actual: br_actual, target: br_target};

    // Head fields come straight from storage, so they are defined even when the FIFO is empty.
    assign head_entry        = slots[head];
    assign update_pc         = head_entry.pc;
    assign update_prediction = head_entry.prediction;
    assign update_actual     = head_entry.actual;
    assign update_target     = head_entry.target;
    assign head_mispredicted = head_entry.prediction != head_entry.actual;

    // Slot storage: cleared on reset; written only by a push that is not cancelled by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (!flush && push) begin
            slots[tail] <= tail_entry;
        end
    end

    // Pointers and occupancy: reset beats flush, flush beats push/pop; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Mispredict statistics: counts drained mispredictions, sticks at all-ones, ignores flushed pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_count <= '0;
        end else if (!flush && pop && head_mispredicted && (mispredict_count != 16'hFFFF)) begin
            mispredict_count <= mispredict_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_bp_update_fifo.sv
module tb_bp_update_fifo;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic [31:0] br_pc;
    logic        br_prediction;
    logic        br_actual;
    logic [31:0] br_target;
    logic        br_ready;
    logic        flush;
    logic        update_ready;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_prediction;
    logic        update_actual;
    logic [31:0] update_target;
    logic [15:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
        logic        act;
        logic [31:0] tgt;
    } ent_t;

    // Reference model: ordered list of buffered branches and the drained mispredict tally.
    ent_t q[$];
    int   mcnt = 0;

    bp_update_fifo #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .br_valid          (br_valid),
        .br_pc             (br_pc),
        .br_prediction     (br_prediction),
        .br_actual         (br_actual),
        .br_target         (br_target),
        .br_ready          (br_ready),
        .flush             (flush),
        .update_ready      (update_ready),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_prediction (update_prediction),
        .update_actual     (update_actual),
        .update_target     (update_target),
        .mispredict_count  (mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one edge using the currently driven inputs, then step the clock.
    task automatic tick();
        bit   push_m;
        bit   pop_m;
        ent_t e;
        push_m = br_valid && (q.size() < DEPTH) && !rst;
        pop_m  = (q.size() != 0) && update_ready;
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop_m) begin
                e = q.pop_front();
                if (e.pred != e.act && mcnt < 65535) mcnt++;
            end
            if (push_m) begin
                e = '{pc: br_pc, pred: br_prediction, act: br_actual, tgt: br_target};
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        br_valid = 0; br_pc = 0; br_prediction = 0; br_actual = 0; br_target = 0;
        flush = 0; update_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        #1;
        checks++;
        if (br_ready !== 1'b0) begin errors++; $display("FAIL reset_br_ready_low got %b want 0", br_ready); end
        tick();
        tick();
        rst = 0;
        #1;
        checks++;
        if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_br_ready_after got %b want 1", br_ready); end
        checks++;
        if (update_valid !== 1'b0) begin errors++; $display("FAIL reset_update_valid got %b want 0", update_valid); end
        checks++;
        if (update_pc !== 32'h0 || update_target !== 32'h0 || update_prediction !== 1'b0 || update_actual !== 1'b0) begin
            errors++;
            $display("FAIL reset_update_fields got pc=%h tgt=%h p=%b a=%b want all zero",
                     update_pc, update_target, update_prediction, update_actual);
        end
        checks++;
        if (mispredict_count !== 16'h0) begin errors++; $display("FAIL reset_mispredict got %h want 0", mispredict_count); end
    endtask

    task automatic test_single();
        br_valid = 1; br_pc = 32'h100; br_prediction = 0; br_actual = 1; br_target = 32'h200;
        update_ready = 1;
        #1;
        checks++;
        if (update_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b want 0", update_valid); end
        tick();
        br_valid = 0;
        #1;
        checks++;
        if (update_valid !== 1'b1 || update_pc !== 32'h100 || update_prediction !== 1'b0 ||
            update_actual !== 1'b1 || update_target !== 32'h200) begin
            errors++;
            $display("FAIL single_present got v=%b pc=%h p=%b a=%b tgt=%h want 1 100 0 1 200",
                     update_valid, update_pc, update_prediction, update_actual, update_target);
        end
        tick();
        #1;
        checks++;
        if (update_valid !== 1'b0 || mispredict_count !== 16'd1) begin
            errors++;
            $display("FAIL single_drained got v=%b cnt=%0d want 0 1", update_valid, mispredict_count);
        end
    endtask

    task automatic test_fill();
        update_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            br_valid = 1; br_pc = i; br_prediction = 1'($urandom_range(0, 1));
            br_actual = 1'($urandom_range(0, 1)); br_target = $urandom();
            #1;
            checks++;
            if (br_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b want 1", i, br_ready); end
            tick();
        end
        br_pc = 5;
        #1;
        checks++;
        if (br_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b want 0", br_ready); end
        tick();
        br_valid = 0;
        #1;
        checks++;
        if (update_pc !== 32'd1 || update_valid !== 1'b1) begin
            errors++; $display("FAIL fill_hold_head got v=%b pc=%0d want 1 1", update_valid, update_pc);
        end
        update_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (update_valid !== 1'b1 || update_pc !== 32'(i)) begin
                errors++; $display("FAIL fill_drain_%0d got v=%b pc=%0d want 1 %0d", i, update_valid, update_pc, i);
            end
            tick();
        end
        #1;
        checks++;
        if (update_valid !== 1'b0 || mispredict_count !== 16'(mcnt)) begin
            errors++; $display("FAIL fill_empty got v=%b cnt=%0d want 0 %0d", update_valid, mispredict_count, mcnt);
        end
    endtask

    task automatic test_back_to_back();
        update_ready = 0;
        br_prediction = 0; br_actual = 0;
        for (int i = 0; i < 2; i++) begin
            br_valid = 1; br_pc = 32'h10 + i; br_target = 32'h1000 + i;
            tick();
        end
        update_ready = 1;
        for (int i = 0; i < 3; i++) begin
            br_valid = 1; br_pc = 32'h12 + i; br_target = 32'h1002 + i;
            #1;
            checks++;
            if (br_ready !== 1'b1 || update_valid !== 1'b1 || update_pc !== 32'h10 + i) begin
                errors++;
                $display("FAIL b2b_cycle_%0d got rdy=%b v=%b pc=%h want 1 1 %h", i, br_ready, update_valid, update_pc, 32'h10 + i);
            end
            tick();
        end
        br_valid = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (update_valid !== 1'b1 || update_pc !== 32'h13 + i || update_target !== 32'h1003 + i) begin
                errors++;
                $display("FAIL b2b_drain_%0d got v=%b pc=%h tgt=%h want 1 %h %h",
                         i, update_valid, update_pc, update_target, 32'h13 + i, 32'h1003 + i);
            end
            tick();
        end
        #1;
        checks++;
        if (update_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", update_valid); end
    endtask

    task automatic test_flush();
        int cnt_before;
        update_ready = 0;
        br_prediction = 1; br_actual = 0;
        for (int i = 0; i < 3; i++) begin
            br_valid = 1; br_pc = 32'h30 + i; br_target = $urandom();
            tick();
        end
        cnt_before = mcnt;
        flush = 1; br_valid = 1; br_pc = 32'h33; update_ready = 1;
        tick();
        flush = 0; br_valid = 0;
        #1;
        checks++;
        if (update_valid !== 1'b0 || br_ready !== 1'b1) begin
            errors++; $display("FAIL flush_empty got v=%b rdy=%b want 0 1", update_valid, br_ready);
        end
        checks++;
        if (mispredict_count !== 16'(cnt_before)) begin
            errors++; $display("FAIL flush_count got %0d want %0d", mispredict_count, cnt_before);
        end
        br_valid = 1; br_pc = 32'h40; br_prediction = 0; br_actual = 0; update_ready = 0;
        tick();
        br_valid = 0;
        #1;
        checks++;
        if (update_valid !== 1'b1 || update_pc !== 32'h40) begin
            errors++; $display("FAIL flush_next_entry got v=%b pc=%h want 1 40", update_valid, update_pc);
        end
        update_ready = 1;
        tick();
    endtask

    task automatic test_reset_mid();
        update_ready = 0;
        br_prediction = 1; br_actual = 0;
        for (int i = 0; i < 2; i++) begin
            br_valid = 1; br_pc = 32'h50 + i; br_target = 32'h5000;
            tick();
        end
        br_valid = 0;
        rst = 1; update_ready = 1;
        #1;
        checks++;
        if (br_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b want 0", br_ready); end
        tick();
        rst = 0;
        #1;
        checks++;
        if (update_valid !== 1'b0 || update_pc !== 32'h0 || mispredict_count !== 16'h0 || br_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after got v=%b pc=%h cnt=%0d rdy=%b want 0 0 0 1",
                     update_valid, update_pc, mispredict_count, br_ready);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            br_valid      = ($urandom_range(0, 3) != 0);
            br_pc         = $urandom();
            br_prediction = 1'($urandom_range(0, 1));
            br_actual     = 1'($urandom_range(0, 1));
            br_target     = $urandom();
            update_ready  = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 40) == 0);
            #1;
            checks++;
            if (br_ready !== (q.size() < DEPTH) || update_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_flags cyc %0d got rdy=%b v=%b want %b %b",
                         c, br_ready, update_valid, q.size() < DEPTH, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if (update_pc !== q[0].pc || update_prediction !== q[0].pred ||
                    update_actual !== q[0].act || update_target !== q[0].tgt) begin
                    errors++;
                    $display("FAIL rand_head cyc %0d got pc=%h p=%b a=%b tgt=%h want %h %b %b %h",
                             c, update_pc, update_prediction, update_actual, update_target,
                             q[0].pc, q[0].pred, q[0].act, q[0].tgt);
                end
            end
            checks++;
            if (mispredict_count !== 16'(mcnt)) begin
                errors++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, mispredict_count, mcnt);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        int guard;
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
        br_valid = 1; br_prediction = 1; br_actual = 0; update_ready = 1;
        guard = 0;
        while (mcnt < 65534 && guard < 70000) begin
            br_pc = guard; br_target = ~guard;
            tick();
            guard++;
        end
        #1;
        checks++;
        if (mispredict_count !== 16'hFFFE) begin
            errors++; $display("FAIL sat_preload got %h want fffe", mispredict_count);
        end
        for (int i = 0; i < 3; i++) tick();
        #1;
        checks++;
        if (mispredict_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_saturated got %h want ffff", mispredict_count);
        end
        br_valid = 0;
        for (int i = 0; i < 3; i++) tick();
        #1;
        checks++;
        if (mispredict_count !== 16'hFFFF || update_valid !== 1'b0) begin
            errors++; $display("FAIL sat_hold got cnt=%h v=%b want ffff 0", mispredict_count, update_valid);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
